// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master sequencer for the unified memory data port
module mem_arbiter #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic          busy,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   inout  wire  [DW-1:0] mem_d
);
   typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_t;
   state_t        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_gnt_q, last_gnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          gnt;
   assign gnt = (m0_req && m1_req) ? ~last_gnt_q : m1_req;
   // next state: grant and latch the request in IDLE, capture read data at the end of RD_B
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_gnt_d = last_gnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      case (state_q)
         IDLE: if (m0_req || m1_req) begin
            owner_d    = gnt;
            last_gnt_d = gnt;
            addr_d     = gnt ? m1_addr : m0_addr;
            wdata_d    = gnt ? m1_wdata : m0_wdata;
            state_d    = (gnt ? m1_we : m0_we) ? WR : RD_A;
         end
         RD_A: state_d = RD_B;
         RD_B: begin
            state_d  = DONE;
            rdata0_d = owner_q ? rdata0_q : mem_d;
            rdata1_d = owner_q ? mem_d : rdata1_q;
         end
         WR:      state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state register; last_gnt resets to 1 so master 0 wins the first contention
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         last_gnt_q <= 1'b1;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_gnt_q <= last_gnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end
   assign busy      = state_q != IDLE;
   assign mem_read  = state_q == RD_A || state_q == RD_B;
   assign mem_write = state_q == WR;
   assign mem_addr  = addr_q;
   assign mem_d     = (state_q == WR) ? wdata_q : {DW{1'bz}};
   assign m0_ack    = state_q == DONE && !owner_q;
   assign m1_ack    = state_q == DONE && owner_q;
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter and sequencer for the data port of the CPU's unified 256×16 memory. It shares the single `read`/`write`/`d_addr`/`d_bus` port between the CPU load/store unit (master 0) and a loader/debug DMA (master 1). It generates the memory's two-cycle read sequence and one-cycle write sequence, and returns data with a per-master acknowledge. The instruction port (`i_addr`/`i_bus`) is not touched by this block.

## Interface
- `AW`, 16, address width; only the low 8 bits select a memory word, all bits are forwarded.
- `DW`, 16, data width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_req`, `m1_req`  in  1  transaction request, level-held until ack.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req is high.
- `m0_addr`, `m1_addr`  in  AW  word address; stable while req is high.
- `m0_wdata`, `m1_wdata`  in  DW  write data; stable while req is high.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  DW  read data; valid from ack, held until that master's next read completes.
- `busy`  out  1  high in any state other than IDLE.
- `mem_read`  out  1  drives memory `read`.
- `mem_write`  out  1  drives memory `write`.
- `mem_addr`  out  AW  drives memory `d_addr`.
- `mem_d`  inout  DW  connects to memory `d_bus`.

## Operation
- FSM states:
  - IDLE: no memory strobes.
  - RD_A: `mem_read`=1, address presented; memory latches `d_mem` at the closing edge.
  - RD_B: `mem_read`=1, same address; `mem_d` carries memory data and is captured at the closing edge into the owner's rdata.
  - WR: `mem_write`=1, `mem_d` driven with the latched wdata; memory commits at the closing edge.
  - DONE: owner's ack=1, strobes low.
- Transitions:
  - IDLE → RD_A when the winner has we=0.
  - IDLE → WR when the winner has we=1.
  - IDLE → IDLE when no req is high.
  - RD_A → RD_B; RD_B → DONE; WR → DONE; DONE → IDLE. All unconditional.
- On leaving IDLE, the block registers the owner, addr, we and wdata. `mem_addr` comes from this register and is constant from RD_A/WR through DONE.
- Arbitration is sampled only in IDLE and is round-robin:
  - Single requester: that master wins.
  - Both requesting: the master not granted last wins.
  - `last_gnt` resets to 1, so master 0 wins the first contention.
- Req is re-sampled in IDLE after DONE. Req still high in that IDLE cycle is treated as a new transaction; a master must drop req in its ack cycle to avoid a repeat.
- Bus rules:
  - `mem_d` is driven only in WR and is high-Z in every other state.
  - `mem_read` and `mem_write` are never high together.
  - `mem_read` is low in WR, so the memory never drives `d_bus` while the arbiter does.
- The non-owner's ack and rdata are unchanged throughout a transaction.
- Addresses ≥ 256 are forwarded unchanged; the behaviour of those addresses is the memory's concern.

## Timing
- Reset (asynchronous, takes effect immediately while `rst_n`=0):
  - State = IDLE, `last_gnt`=1.
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_d`=Z.
  - `m0_ack`=`m1_ack`=0, `m0_rdata`=`m1_rdata`=0, `busy`=0.
- Read, with req sampled in IDLE at edge 0:
  - RD_A in cycle 1, RD_B in cycle 2, ack and valid rdata in cycle 3.
  - Read occupancy is 4 cycles including IDLE.
- Write, with req sampled at edge 0:
  - WR in cycle 1; memory updated at edge 1; ack in cycle 2.
  - Write occupancy is 3 cycles.
- Back-to-back throughput: one read per 4 cycles, one write per 3 cycles. Under continuous contention, grants alternate m0, m1, m0, and so on.
- Reset mid-transaction:
  - Strobes drop asynchronously and the transaction is aborted with no ack.
  - A write is committed only if an edge occurred while in WR.
  - The next request after reset release starts a fresh transaction.
- Req changes outside IDLE are ignored. A withdrawn req does not cancel the transaction in flight.

## Test plan
- Single read: preload mem[20]=16'hFF30. Hold `m0_req`=1, `m0_we`=0, `m0_addr`=20 → `mem_read` high for exactly 2 cycles, then `m0_ack` pulses 1 cycle, `m0_rdata`=16'hFF30 on the 4th cycle after the request, `m1_ack` stays 0.
- Write then read-back: m1 writes 16'hA5A5 to address 40 → `mem_write` high 1 cycle with `mem_d`=16'hA5A5 and ack on cycle 2. A following m1 read of address 40 returns 16'hA5A5.
- Contention: assert both reqs in the same cycle from reset, both reading (m0 address 17, m1 address 19), each dropping req on its ack → m0 is served first, then m1. Each ack fires once, and rdata holds the respective word (16'h0000, 16'h0015).
- Fairness: m0 and m1 hold req continuously with writes → grant order is m0, m1, m0, m1 over 12 cycles. No two consecutive grants go to one master while the other is waiting.
- Bus hygiene: across a mixed random sequence of 200 transactions, assert `mem_read`&`mem_write` is never 1 and `mem_d` is never driven outside WR.
- Reset mid-read: assert `rst_n`=0 during RD_B → all outputs return to reset values immediately and no ack is issued. After release, a new m0 read of address 20 completes normally with 16'hFF30.
